// File: rtl/ham_word_seq_if.sv
// Operand/result bus between the ALU, the word popcount sequencer and the 8-bit weight unit.
// The master side drives requests and the unit's slice count. The slave side is the sequencer.
interface ham_word_seq_if;
    logic        start;
    logic [31:0] operand;
    logic [7:0]  slice_out;
    logic [3:0]  slice_cnt;
    logic        busy;
    logic        done;
    logic [5:0]  count;

    modport master (
        output start, operand, slice_cnt,
        input  slice_out, busy, done, count
    );

    modport slave (
        input  start, operand, slice_cnt,
        output slice_out, busy, done, count
    );
endinterface

// File: rtl/ham_word_seq.sv
// Purpose: 32-bit popcount by feeding one byte per cycle through an external 8-bit weight unit.
// Latency: 5 cycles from start to done; with HAM_WORD_EARLY_EXIT_EN it is 2..5 and stops once upper bytes are zero.
// Backpressure: start is taken only in IDLE/DONE, ignored (not queued) while busy; done is a 1-cycle pulse.
module ham_word_seq (
    input  logic           clk,
    input  logic           rst_n,
    ham_word_seq_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [31:0] opnd_r;
    logic [5:0]  acc;
    logic [5:0]  count_r;
    logic [1:0]  idx;
    logic [7:0]  slice_r;
    logic        busy_r;
    logic        done_r;

    logic [5:0]  acc_nxt;
    logic [1:0]  idx_nxt;
    logic        last_slice;

    // slice_cnt is the unit's combinational answer for the byte on slice_out this cycle
    assign acc_nxt = acc + {2'b00, bus.slice_cnt};
    assign idx_nxt = idx + 2'd1;

`ifdef HAM_WORD_EARLY_EXIT_EN
    // Finish as soon as every byte above the current one is zero.
    always_comb begin
        last_slice = 1'b1;
        case (idx)
            2'd0:    last_slice = (opnd_r[31:8]  == 24'd0);
            2'd1:    last_slice = (opnd_r[31:16] == 16'd0);
            2'd2:    last_slice = (opnd_r[31:24] == 8'd0);
            default: last_slice = 1'b1;
        endcase
    end
`else
    assign last_slice = (idx == 2'd3);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            opnd_r  <= 32'd0;
            acc     <= 6'd0;
            count_r <= 6'd0;
            idx     <= 2'd0;
            slice_r <= 8'h00;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state   <= RUN;
                        opnd_r  <= bus.operand;
                        acc     <= 6'd0;
                        idx     <= 2'd0;
                        slice_r <= bus.operand[7:0];
                        busy_r  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    idx <= idx_nxt;
                    if (last_slice) begin
                        state   <= DONE;
                        count_r <= acc_nxt;
                        slice_r <= 8'h00;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        slice_r <= opnd_r[{idx_nxt, 3'b000} +: 8];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.slice_out = slice_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.count     = count_r;

endmodule

// File: tb/tb_ham_word_seq.sv
// Directed bench for ham_word_seq; the 8-bit weight unit is modelled with $countones.
// Latency expectations follow HAM_WORD_EARLY_EXIT_EN when it is defined.
module tb_ham_word_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ham_word_seq_if bus ();

    assign bus.slice_cnt = 4'($countones(bus.slice_out));

    ham_word_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef HAM_WORD_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Latency counts edges from the accept edge up to the one that raises done.
    task automatic run_op(input logic [31:0] op, input int exp_lat, input logic [5:0] exp_cnt,
                          input bit poke, input string tag);
        int lat;
        int nbusy;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.operand = op;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.operand = 32'hA5A5_5A5A;
        lat   = 1;
        nbusy = 0;
        while (!bus.done && lat < 12) begin
            if (bus.busy) begin
                if (nbusy < 4) chk({tag, "_slice"}, {24'd0, bus.slice_out}, {24'd0, op[nbusy*8 +: 8]});
                nbusy++;
            end
            if (poke) begin
                bus.start   = (lat == 1);
                bus.operand = 32'hFFFF_FFFF;
            end
            @(posedge clk); #1;
            lat++;
        end
        bus.start = 1'b0;
        chk({tag, "_lat"},   lat,           exp_lat);
        chk({tag, "_count"}, bus.count,     exp_cnt);
        chk({tag, "_nbusy"}, nbusy,         exp_lat - 1);
        chk({tag, "_busy_in_done"}, bus.busy, 1'b0);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, bus.done,      1'b0);
        chk({tag, "_hold"},  bus.count,     exp_cnt);
        chk({tag, "_idle_busy"}, bus.busy,  1'b0);
        chk({tag, "_idle_slice"}, bus.slice_out, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ndone;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.operand = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  bus.busy,      1'b0);
        chk("rst_done",  bus.done,      1'b0);
        chk("rst_count", bus.count,     6'd0);
        chk("rst_slice", bus.slice_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(32'hFFFF_FFFF, 5, 6'd32, 1'b0, "full");
        run_op(32'h0F0F_0F0F, 5, 6'd16, 1'b0, "mixed");
        run_op(32'h0000_0000, EE ? 2 : 5, 6'd0, 1'b1, "zero_ign");
        run_op(32'h8000_0001, 5, 6'd2, 1'b0, "ends");

        // Abort mid-run: the previous count (2) must be cleared and no done may follow.
        @(negedge clk);
        bus.start   = 1'b1;
        bus.operand = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        chk("mid_busy", bus.busy, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_busy",  bus.busy,      1'b0);
        chk("abort_done",  bus.done,      1'b0);
        chk("abort_count", bus.count,     6'd0);
        chk("abort_slice", bus.slice_out, 8'h00);
        ndone = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
        end
        chk("abort_no_done", ndone, 0);

        run_op(32'h0000_00F0, EE ? 2 : 5, 6'd4, 1'b0, "fresh");

        // Back-to-back: start stays high through the first DONE cycle.
        @(negedge clk);
        bus.start   = 1'b1;
        bus.operand = 32'h0000_0001;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.done && n < 12);
        chk("b2b_lat1",  n,         EE ? 2 : 5);
        chk("b2b_cnt1",  bus.count, 6'd1);
        bus.operand = 32'h0000_0003;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("b2b_accept", bus.busy,  1'b1);
        chk("b2b_hold",   bus.count, 6'd1);
        n = 1;
        while (!bus.done && n < 12) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_lat2", n,         EE ? 2 : 5);
        chk("b2b_cnt2", bus.count, 6'd2);

        run_op(32'h0000_00FF, EE ? 2 : 5, 6'd8, 1'b0, "ee_low");
        run_op(32'h00FF_0000, EE ? 4 : 5, 6'd8, 1'b0, "ee_mid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ham_word_seq.md
# ham_word_seq

Multi-cycle 32-bit Hamming-weight sequencer sitting directly around the 8-bit Hamming-weight unit.
- Upstream side: latches a 32-bit operand on a start handshake and presents it one byte per cycle to the 8-bit unit.
- Downstream side: consumes the unit's 4-bit count and accumulates it into a 6-bit result.
- Completion: signals done with a one-cycle pulse.

Gives the ALU a word-wide popcount without widening the combinational tree.

## Interface
Parameters:
- none (word width fixed at 32, slice width fixed at 8)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  reset; synchronous and active-low, sampled on rising edge of clk
- start  input  1  request; accepted only in IDLE or DONE
- operand  input  32  word to count, sampled in the accept cycle only
- slice_out  output  8  current byte to the 8-bit Hamming-weight unit
- slice_cnt  input  4  popcount of slice_out from that unit (combinational, 0..8)
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when count is final
- count  output  6  popcount result, 0..32; holds until next accept

## Operation
- States: IDLE, RUN, DONE. Slice index idx is 2 bits.
- IDLE:
  - start=1 → latch operand into opnd_r, clear acc, idx=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - slice_out = opnd_r[idx*8 +: 8].
  - Each cycle: acc <= acc + {2'b0, slice_cnt}, then idx <= idx + 1.
  - After idx=3 → go to DONE; count <= final acc, loaded in the same edge.
- DONE:
  - done=1 for exactly this cycle.
  - start=1 → accepted exactly as in IDLE, giving back-to-back operation; otherwise go to IDLE.
- slice_out outside RUN is 8'h00.
- start in RUN is ignored, not queued. operand changes in RUN have no effect.
- Arithmetic: acc and count are 6 bits. Maximum 4×8=32 cannot overflow.
- Reset (rst_n=0 at an edge, any state including mid-RUN):
  - Go to IDLE.
  - Clear opnd_r, acc, idx and count.
  - busy=0, done=0, slice_out=0.
  - No done pulse is produced for the aborted operation.

## Timing
- Reset values: busy=0, done=0, count=0, slice_out=8'h00.
- Start sampled high at edge T:
  - RUN during cycles T+1..T+4, with busy=1 and slice 0..3 in that order.
  - done=1 and count valid during cycle T+5.
  - busy=0 from T+5.
- Latency: 5 cycles from start edge to done (build without the macro).
- Back-to-back: start high in the DONE cycle → next RUN begins the following cycle; throughput is one word per 5 cycles.
- count changes only at the edge entering DONE, or on reset. It is stable at all other times.
- slice_cnt must settle within the same cycle as slice_out, so the combinational path runs slice_out → unit → acc.

## Configuration
- Macro: HAM_WORD_EARLY_EXIT_EN.
- Defined:
  - In RUN at index k, if opnd_r bits [31:(k+1)*8] are all zero (for k<3), accumulate this slice and go to DONE directly.
  - Latency becomes 2..5 cycles: 1 RUN cycle for operands ≤ 0x000000FF, up to 4 RUN cycles.
  - count and done behave identically otherwise.
- Not defined: always 4 RUN cycles, fixed 5-cycle latency.

## Test plan
- Full word: reset, then start with operand=32'hFFFF_FFFF → busy high for 4 cycles, done pulse at T+5, count=32.
- Mixed pattern: operand=32'h0F0F_0F0F → count=16. Then operand=32'h8000_0001 → count=2. Check slice_out sequence 8'h0F ×4 in the first operation.
- Zero and ignore rules: operand=0 → count=0 with a done pulse. start re-asserted during RUN with operand=32'hFFFF_FFFF → ignored, count stays at the first result.
- Reset mid-operation: drive rst_n=0 at T+2 → the next cycle shows busy=0, done=0, count=0, and no done pulse follows. A fresh start with 32'h0000_00F0 → count=4.
- Back-to-back: start held high across DONE with operands 32'h1 then 32'h3 → done at T+5 (count=1) and T+10 (count=2).
- Early exit, with HAM_WORD_EARLY_EXIT_EN: operand=32'h0000_00FF → done at T+2, count=8. Operand=32'h00FF_0000 → done at T+4, count=8. Without the macro, both complete at T+5.
